// File: rtl/gpio_seg7_scan.sv
// Multiplexed hex driver for an 8-digit 7-segment display fed by the GPIO output register.
// Define GPIO_SEG7_LZB_EN to enable leading-zero blanking.
module gpio_seg7_scan #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic [31:0]           in,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         snap_q, snap_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  last;
  logic                  blank;
  logic [SW-1:0]         sh;
  logic [NUM_DIGITS-1:0] dp_sh;
  logic                  unused_in;

  assign unused_in = ^in;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick      = (cnt_q == CW'(CLK_DIV - 1));
    last      = (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    if (tick) begin
      idx_d = last ? '0 : idx_q + IW'(1);
      if (last) begin
        snap_d    = in[SW-1:0];
        snap_dp_d = dp_mask;
      end
    end
    wrap_d  = tick && last;
    // Aligned with the first output cycle showing digit 0 of the new snapshot
    frame_d = wrap_q;

    sh    = snap_q >> {idx_q, 2'b00};
    dp_sh = snap_dp_q >> idx_q;
`ifdef GPIO_SEG7_LZB_EN
    blank = (idx_q != '0) && (sh == '0);
`else
    blank = 1'b0;
`endif
    seg_d = hex7(sh[3:0]);
    an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    dp_d  = blank ? 1'b1 : ~dp_sh[0];
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      wrap_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      wrap_q    <= wrap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_gpio_seg7_scan.sv
// Bench for gpio_seg7_scan: two instances (4x8 and 1x4) against an arithmetic scan model.
module tb_gpio_seg7_scan;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] in_v = '0;
  logic [7:0]  dpm = '0;

  logic [7:0] an0;
  logic [6:0] seg0;
  logic       dp0, fr0;
  logic [3:0] an1;
  logic [6:0] seg1;
  logic       dp1, fr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_seg7_scan #(.CLK_DIV(4), .NUM_DIGITS(8)) u0 (
    .clk(clk), .Rst(Rst), .in(in_v), .dp_mask(dpm),
    .an(an0), .seg(seg0), .dp(dp0), .frame(fr0)
  );

  gpio_seg7_scan #(.CLK_DIV(1), .NUM_DIGITS(4)) u1 (
    .clk(clk), .Rst(Rst), .in(in_v), .dp_mask(dpm[3:0]),
    .an(an1), .seg(seg1), .dp(dp1), .frame(fr1)
  );

  localparam logic [6:0] HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          dv [2] = '{4, 1};
  int          nd [2] = '{8, 4};
  longint      k = 0;
  logic [31:0] snap [2];
  logic [7:0]  sdp  [2];
  bit          lzb;

  task automatic cmp(input string tag, input int i, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s u%0d k=%0d: got %h expected %h", tag, i, k, o, e);
    end
  endtask

  task automatic obs(input int i, output logic [7:0] a, output logic [6:0] s,
                     output logic d, output logic f);
    if (i == 0) begin
      a = an0; s = seg0; d = dp0; f = fr0;
    end else begin
      a = {4'hF, an1}; s = seg1; d = dp1; f = fr1;
    end
  endtask

  task automatic check(input int i, input bit in_rst);
    logic [7:0]  a, ea;
    logic [6:0]  s, es;
    logic        d, ed, f, ef;
    longint unsigned sm, up;
    int dg, dn;
    bit blank;
    obs(i, a, s, d, f);
    if (in_rst) begin
      ea = 8'hFF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
    end else begin
      dn = dv[i] * nd[i];
      dg = int'(((k - 1) / dv[i]) % nd[i]);
      sm = longint'(snap[i]) & ((64'h1 << (4 * nd[i])) - 1);
      up = sm >> (4 * dg);
      blank = lzb && dg > 0 && up == 0;
      ea = 8'hFF;
      if (!blank) ea[dg] = 1'b0;
      es = HEX[up[3:0]];
      ed = blank ? 1'b1 : ~sdp[i][dg];
      ef = ((k - 1) % dn == 0) && (k - 1 >= dn);
    end
    cmp("an", i, 32'(a), 32'(ea));
    cmp("seg", i, 32'(s), 32'(es));
    cmp("dp", i, 32'(d), 32'(ed));
    cmp("frame", i, 32'(f), 32'(ef));
  endtask

  task automatic step(input logic r, input logic [31:0] v, input logic [7:0] m);
    Rst = r; in_v = v; dpm = m;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0;
      for (int i = 0; i < 2; i++) begin
        snap[i] = '0; sdp[i] = '0;
        check(i, 1'b1);
      end
    end else begin
      k++;
      for (int i = 0; i < 2; i++) begin
        check(i, 1'b0);
        if (k % (dv[i] * nd[i]) == 0) begin
          snap[i] = v; sdp[i] = m;
        end
      end
    end
  endtask

  task automatic run(input int n, input logic [31:0] v, input logic [7:0] m);
    for (int c = 0; c < n; c++) step(1'b0, v, m);
  endtask

  initial begin
`ifdef GPIO_SEG7_LZB_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      snap[i] = '0; sdp[i] = '0;
    end
    #2;
    for (int c = 0; c < 3; c++) step(1'b1, 32'h0, 8'h0);
    run(32, 32'h0, 8'h0);
    run(100, 32'h76543210, 8'h01);
    // idx of u0 is mid-frame here; switch value
    run(2, 32'h76543210, 8'h01);
    run(80, 32'hFFFFFFFF, 8'h00);
    run(21, 32'h12345678, 8'hA5);
    step(1'b1, 32'h12345678, 8'hA5);
    run(40, 32'h12345678, 8'hA5);
    run(70, 32'h000000A5, 8'hFF);
    run(70, 32'h0, 8'h81);
    for (int r = 0; r < 60; r++) begin
      logic [31:0] v;
      logic [7:0]  m;
      int          sh;
      sh = int'($urandom_range(0, 7));
      v = $urandom >> (4 * sh);
      m = 8'($urandom);
      if ($urandom_range(0, 19) == 0) step(1'b1, v, m);
      run(int'($urandom_range(1, 20)), v, m);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
